// File: rtl/cnn_pkg.sv
// Shared widths and state type for the CNN layer controllers and the load arbiter.
package cnn_pkg;

  parameter int unsigned DATA_SZ = 16;
  parameter int unsigned ADDR_SZ = 16;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE,
    GAP
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority encoder: the first requester after lastGrant wins.
module rr_pick #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] lastGrant,
  output logic [$clog2(NUM_REQ)-1:0] winner,
  output logic                       valid
);

  localparam int unsigned IdW = $clog2(NUM_REQ);

  // Walk offsets from farthest to nearest so the nearest asserted requester overrides.
  always_comb begin
    logic [IdW-1:0] sel;
    winner = lastGrant;
    valid  = 1'b0;
    sel    = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      sel = IdW'((32'(lastGrant) + 32'(k)) % NUM_REQ);
      if (req[sel]) begin
        winner = sel;
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/load_arbiter.sv
// Round-robin arbiter sharing the memory load block among the layer controllers.
module load_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_SZ = cnn_pkg::DATA_SZ,
  parameter int unsigned ADDR_SZ = cnn_pkg::ADDR_SZ
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_REQ-1:0]                reqEnable,
  input  logic [NUM_REQ-1:0][ADDR_SZ-1:0]   reqAddr,
  input  logic [NUM_REQ-1:0][DATA_SZ-1:0]   reqSize,
  output logic [NUM_REQ-1:0]                reqDone,
  output logic                              loadEnable,
  output logic [ADDR_SZ-1:0]                loadAddr,
  output logic [DATA_SZ-1:0]                loadSize,
  input  logic                              loadDone,
  output logic [$clog2(NUM_REQ)-1:0]        grantId,
  output logic                              busy
);

  import cnn_pkg::*;

  localparam int unsigned IdW = $clog2(NUM_REQ);

  arb_state_t         state_q, state_d;
  logic               load_en_q, load_en_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [ADDR_SZ-1:0] addr_q, addr_d;
  logic [DATA_SZ-1:0] size_q, size_d;
  logic [IdW-1:0]     gid_q, gid_d;
  logic [IdW-1:0]     last_q, last_d;

  logic [IdW-1:0]     pick_id;
  logic               pick_valid;

  rr_pick #(
    .NUM_REQ(NUM_REQ)
  ) u_rr_pick (
    .req      (reqEnable),
    .lastGrant(last_q),
    .winner   (pick_id),
    .valid    (pick_valid)
  );

  always_comb begin
    state_d   = state_q;
    load_en_d = load_en_q;
    done_d    = '0;
    addr_d    = addr_q;
    size_d    = size_q;
    gid_d     = gid_q;
    last_d    = last_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d   = LOAD;
          load_en_d = 1'b1;
          addr_d    = reqAddr[pick_id];
          size_d    = reqSize[pick_id];
          gid_d     = pick_id;
        end
      end
      LOAD: begin
        if (loadDone) begin
          state_d        = DONE;
          load_en_d      = 1'b0;
          done_d[gid_q]  = 1'b1;
          last_d         = gid_q;
        end
      end
      DONE:    state_d = GAP;
      // One dead cycle lets the served requester drop its stale enable.
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      load_en_q <= 1'b0;
      done_q    <= '0;
      addr_q    <= '0;
      size_q    <= '0;
      gid_q     <= '0;
      last_q    <= IdW'(NUM_REQ - 1);
    end else begin
      state_q   <= state_d;
      load_en_q <= load_en_d;
      done_q    <= done_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
      gid_q     <= gid_d;
      last_q    <= last_d;
    end
  end

  assign reqDone    = done_q;
  assign loadEnable = load_en_q;
  assign loadAddr   = addr_q;
  assign loadSize   = size_q;
  assign grantId    = gid_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_load_arbiter.sv
// Self-checking bench for load_arbiter: vector table, corner sequences, random vs. model.
module tb_load_arbiter;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned DATA_SZ = 16;
  localparam int unsigned ADDR_SZ = 16;

  logic clk = 1'b0;
  logic reset;
  logic [NUM_REQ-1:0]              reqEnable;
  logic [NUM_REQ-1:0][ADDR_SZ-1:0] reqAddr;
  logic [NUM_REQ-1:0][DATA_SZ-1:0] reqSize;
  logic [NUM_REQ-1:0]              reqDone;
  logic                            loadEnable;
  logic [ADDR_SZ-1:0]              loadAddr;
  logic [DATA_SZ-1:0]              loadSize;
  logic                            loadDone;
  logic [1:0]                      grantId;
  logic                            busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  load_arbiter #(
    .NUM_REQ(NUM_REQ),
    .DATA_SZ(DATA_SZ),
    .ADDR_SZ(ADDR_SZ)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .reqEnable (reqEnable),
    .reqAddr   (reqAddr),
    .reqSize   (reqSize),
    .reqDone   (reqDone),
    .loadEnable(loadEnable),
    .loadAddr  (loadAddr),
    .loadSize  (loadSize),
    .loadDone  (loadDone),
    .grantId   (grantId),
    .busy      (busy)
  );

  // Transaction-level reference: a grant is outstanding or not, and after each
  // completion the arbiter is deaf for a fixed cooldown before the next pick.
  logic        m_en;
  logic [3:0]  m_done;
  logic [15:0] m_addr, m_size;
  logic [1:0]  m_gid;
  int          m_last;
  int          m_cool;

  function automatic void model_step();
    bit found;
    if (reset) begin
      m_en = 1'b0; m_done = '0; m_addr = '0; m_size = '0; m_gid = '0;
      m_last = NUM_REQ - 1; m_cool = 0;
      return;
    end
    m_done = '0;
    if (m_en) begin
      if (loadDone) begin
        m_en = 1'b0;
        m_done = 4'(1 << m_gid);
        m_last = int'(m_gid);
        m_cool = 2;
      end
    end else if (m_cool > 0) begin
      m_cool--;
    end else begin
      found = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
        int c;
        c = (m_last + k) % NUM_REQ;
        if (!found && reqEnable[c]) begin
          found = 1'b1;
          m_en = 1'b1;
          m_gid = 2'(c);
          m_addr = reqAddr[c];
          m_size = reqSize[c];
        end
      end
    end
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] outs();
    return 64'({loadEnable, reqDone, grantId, busy, loadAddr, loadSize});
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("model", outs(), 64'({m_en, m_done, m_gid, (m_en || m_cool > 0), m_addr, m_size}));
  endtask

  task automatic do_reset();
    reset = 1'b1; reqEnable = '0; loadDone = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  typedef struct {
    logic        rst;
    logic [3:0]  en;
    logic        ld;
    logic        le;
    logic [3:0]  dn;
    logic [1:0]  gid;
    logic        bsy;
    logic [15:0] addr;
    logic [15:0] size;
  } vec_t;

  vec_t tbl[12];

  initial begin : main
    int le_cnt, dn_cnt, waited;
    reset = 1'b1; reqEnable = '0; loadDone = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      reqAddr[i] = 16'(16'h1000 + i);
      reqSize[i] = 16'(i + 1);
    end

    // rst en ld | le done gid busy addr size
    tbl[0]  = '{1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 16'h0000, 16'h0000};
    tbl[1]  = '{1'b0, 4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0, 16'h0000, 16'h0000};
    tbl[2]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 16'h0000, 16'h0000};
    tbl[3]  = '{1'b0, 4'b0100, 1'b0, 1'b1, 4'b0000, 2'd2, 1'b1, 16'h1002, 16'h0003};
    tbl[4]  = '{1'b0, 4'b0100, 1'b1, 1'b0, 4'b0100, 2'd2, 1'b1, 16'h1002, 16'h0003};
    tbl[5]  = '{1'b0, 4'b0100, 1'b1, 1'b0, 4'b0000, 2'd2, 1'b1, 16'h1002, 16'h0003};
    tbl[6]  = '{1'b0, 4'b0100, 1'b1, 1'b0, 4'b0000, 2'd2, 1'b0, 16'h1002, 16'h0003};
    tbl[7]  = '{1'b0, 4'b0010, 1'b0, 1'b1, 4'b0000, 2'd1, 1'b1, 16'h1001, 16'h0002};
    tbl[8]  = '{1'b0, 4'b0011, 1'b0, 1'b1, 4'b0000, 2'd1, 1'b1, 16'h1001, 16'h0002};
    tbl[9]  = '{1'b1, 4'b0011, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0, 16'h0000, 16'h0000};
    tbl[10] = '{1'b0, 4'b1011, 1'b0, 1'b1, 4'b0000, 2'd0, 1'b1, 16'h1000, 16'h0001};
    tbl[11] = '{1'b0, 4'b1011, 1'b1, 1'b0, 4'b0001, 2'd0, 1'b1, 16'h1000, 16'h0001};

    for (int i = 0; i < 12; i++) begin
      reset = tbl[i].rst; reqEnable = tbl[i].en; loadDone = tbl[i].ld;
      tick();
      chk($sformatf("vec%0d", i), outs(),
          64'({tbl[i].le, tbl[i].dn, tbl[i].gid, tbl[i].bsy, tbl[i].addr, tbl[i].size}));
    end

    // Single requester, done asserted 10 cycles after the grant.
    do_reset();
    reqAddr[0] = 16'h0100; reqSize[0] = 16'd28; reqEnable = 4'b0001;
    le_cnt = 0; dn_cnt = 0;
    for (int c = 0; c < 11; c++) begin
      tick();
      if (loadEnable) le_cnt++;
      if (reqDone != 0) dn_cnt++;
    end
    chk("single_addr", 64'(loadAddr), 64'h0100);
    chk("single_size", 64'(loadSize), 64'd28);
    loadDone = 1'b1;
    tick();
    chk("single_done", 64'(reqDone), 64'b0001);
    if (reqDone != 0) dn_cnt++;
    if (loadEnable) le_cnt++;
    loadDone = 1'b0; reqEnable = '0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (loadEnable) le_cnt++;
      if (reqDone != 0) dn_cnt++;
    end
    chk("single_le_cycles", 64'(le_cnt), 64'd11);
    chk("single_done_cnt", 64'(dn_cnt), 64'd1);
    chk("single_idle", 64'(busy), 64'd0);

    // All four requesting continuously: round-robin order with a gap between grants.
    do_reset();
    reqEnable = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      waited = 0;
      while (!loadEnable && waited < 20) begin
        tick();
        waited++;
      end
      chk("rr_wait_bound", 64'(waited < 20), 64'd1);
      if (g > 0) chk("rr_gap", 64'(waited), 64'd3);
      chk("rr_grant", 64'(grantId), 64'(g % 4));
      tick(); tick();
      loadDone = 1'b1;
      tick();
      chk("rr_done", 64'(reqDone), 64'(1 << (g % 4)));
      loadDone = 1'b0;
    end

    // Address change during LOAD must not reach the load block.
    do_reset();
    reqAddr[2] = 16'h0200; reqEnable = 4'b0100;
    tick();
    reqAddr[2] = 16'h0300;
    tick(); tick(); tick();
    chk("addr_frozen", 64'(loadAddr), 64'h0200);
    loadDone = 1'b1;
    tick();
    chk("addr_frozen_done", 64'(loadAddr), 64'h0200);
    loadDone = 1'b0; reqEnable = '0;
    tick(); tick(); tick();

    // loadDone held for three cycles; requester drops enable after its reqDone.
    do_reset();
    reqEnable = 4'b0010;
    tick(); tick();
    loadDone = 1'b1;
    dn_cnt = 0; le_cnt = 0;
    tick();
    if (reqDone != 0) dn_cnt++;
    reqEnable = '0;
    tick(); if (reqDone != 0) dn_cnt++;
    tick(); if (reqDone != 0) dn_cnt++;
    loadDone = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (reqDone != 0) dn_cnt++;
      if (loadEnable) le_cnt++;
    end
    chk("held_done_pulses", 64'(dn_cnt), 64'd1);
    chk("held_no_regrant", 64'(le_cnt), 64'd0);

    // Randomised traffic against the reference model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 199) == 0);
      reqEnable = 4'($urandom_range(0, 15));
      for (int i = 0; i < NUM_REQ; i++) begin
        reqAddr[i] = 16'($urandom);
        reqSize[i] = 16'($urandom);
      end
      loadDone = ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
